controller_datapath: RTL

CONTROLLER_DATAPATH -- requirements
Module: controller_datapath

---
 rtl/controller_datapath.sv | 79 +++++++
 1 files changed

// File: rtl/controller_datapath.sv
// Function-code driven 8-bit working register with hold/increment/decrement/load,
// optional saturation, sticky overflow/underflow flags, change pulse and op counter.
module controller_datapath (
    input  logic        clock,
    input  logic        reset,
    input  logic        F1,
    input  logic        F0,
    input  logic [7:0]  D,
    input  logic        sat,
    input  logic        clr_flags,
    output logic [7:0]  Q,
    output logic        zero,
    output logic        ovf,
    output logic        unf,
    output logic        changed,
    output logic [15:0] op_count
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic [1:0] code;
    logic [7:0] next_q;
    logic       ovf_event;
    logic       unf_event;

    assign code = {F1, F0};
    assign zero = (Q == 8'h00);

    // At the range limits the register either wraps or sticks.
    // The flag event fires in both cases.
    always_comb begin
        next_q    = Q;
        ovf_event = 1'b0;
        unf_event = 1'b0;
        case (code)
            OP_INC: begin
                if (Q == 8'hFF) begin
                    ovf_event = 1'b1;
                    next_q    = sat ? 8'hFF : 8'h00;
                end else begin
                    next_q = Q + 8'd1;
                end
            end
            OP_DEC: begin
                if (Q == 8'h00) begin
                    unf_event = 1'b1;
                    next_q    = sat ? 8'h00 : 8'hFF;
                end else begin
                    next_q = Q - 8'd1;
                end
            end
            OP_LOAD: next_q = D;
            default: next_q = Q;
        endcase
    end

    // A new flag event takes priority over a simultaneous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Q        <= 8'h00;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            changed  <= 1'b0;
            op_count <= 16'h0000;
        end else begin
            Q       <= next_q;
            changed <= (next_q != Q);
            ovf     <= ovf_event | (ovf & ~clr_flags);
            unf     <= unf_event | (unf & ~clr_flags);
            if ((code != OP_HOLD) && (op_count != 16'hFFFF)) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule
